axi_lite_xbar_1to3: RTL and testbench

- Single-master AXI4-Lite address-decoding crossbar between the core's LSU and three slaves:
  - port 0: main memory;
  - port 1: UART;
  - port 2: CLINT timer.
- Read and write directions are independent, with one outstanding transaction per direction.
- Unmapped addresses are answered internally with DECERR; no slave sees them.

---
 rtl/axi_lite_pkg.sv | 15 +
 rtl/xbar_addr_decode.sv | 30 +++
 rtl/axi_lite_xbar_1to3.sv | 214 +++++++++++++++++++++
 tb/tb_axi_lite_xbar_1to3.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes, slave select indices and FSM state encodings for the LSU crossbar.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SEL_MEM   = 2'd0;
  localparam logic [1:0] SEL_UART  = 2'd1;
  localparam logic [1:0] SEL_CLINT = 2'd2;
  localparam logic [1:0] SEL_ERR   = 2'd3;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_ERR} wr_state_t;

endpackage

// File: rtl/xbar_addr_decode.sv
// Combinational address decoder: maps a 32-bit address to a slave select, CLINT > UART > MEM.
module xbar_addr_decode
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
  parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE  = 32'h0000_0008,
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
  input  logic [31:0] addr,
  output logic [1:0]  sel
);

  logic hit_mem, hit_uart, hit_clint;

  // Wrapping subtraction makes addresses below a base land far above its size.
  assign hit_mem   = (addr - MEM_BASE)   < MEM_SIZE;
  assign hit_uart  = (addr - UART_BASE)  < UART_SIZE;
  assign hit_clint = (addr - CLINT_BASE) < CLINT_SIZE;

  always_comb begin
    sel = SEL_ERR;
    if (hit_clint)     sel = SEL_CLINT;
    else if (hit_uart) sel = SEL_UART;
    else if (hit_mem)  sel = SEL_MEM;
  end

endmodule

// File: rtl/axi_lite_xbar_1to3.sv
// AXI4-Lite 1-to-3 crossbar (MEM/UART/CLINT), one outstanding read and one outstanding write,
// unmapped accesses answered internally with DECERR; busy directions hold the master off via ready=0.
module axi_lite_xbar_1to3
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
  parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE  = 32'h0000_0008,
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arvalid,
  input  logic [2:0]  s_arready,
  input  logic [95:0] s_rdata,
  input  logic [5:0]  s_rresp,
  input  logic [2:0]  s_rvalid,
  output logic [2:0]  s_rready,
  output logic [31:0] s_awaddr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic [2:0]  s_awvalid,
  input  logic [2:0]  s_awready,
  output logic [2:0]  s_wvalid,
  input  logic [2:0]  s_wready,
  input  logic [5:0]  s_bresp,
  input  logic [2:0]  s_bvalid,
  output logic [2:0]  s_bready
);

  rd_state_t   r_state, r_state_nxt;
  wr_state_t   w_state, w_state_nxt;
  logic [1:0]  ar_dec, aw_dec, r_sel, w_sel, w_sel_now;
  logic [2:0]  r_oh, w_oh;
  logic [31:0] sel_rdata;
  logic [1:0]  sel_rresp, sel_bresp;
  logic        sel_rvalid, sel_bvalid, sel_awready, sel_wready;
  logic        aw_got, w_got, aw_done, w_done, aw_hs, w_hs;

  xbar_addr_decode #(
    .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE), .UART_BASE(UART_BASE),
    .UART_SIZE(UART_SIZE), .CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)
  ) u_rd_dec (.addr(araddr), .sel(ar_dec));

  xbar_addr_decode #(
    .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE), .UART_BASE(UART_BASE),
    .UART_SIZE(UART_SIZE), .CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)
  ) u_wr_dec (.addr(awaddr), .sel(aw_dec));

  // SEL_ERR yields an all-zero one-hot, so no slave is ever driven for it.
  assign r_oh = {r_sel == SEL_CLINT, r_sel == SEL_UART, r_sel == SEL_MEM};
  assign w_oh = {w_sel == SEL_CLINT, w_sel == SEL_UART, w_sel == SEL_MEM};

  assign sel_rvalid  = |(s_rvalid & r_oh);
  assign sel_bvalid  = |(s_bvalid & w_oh);
  assign sel_awready = |(s_awready & w_oh);
  assign sel_wready  = |(s_wready & w_oh);

  always_comb begin
    sel_rdata = '0;
    sel_rresp = '0;
    sel_bresp = '0;
    for (int i = 0; i < 3; i++) begin
      sel_rdata = sel_rdata | (s_rdata[32*i +: 32] & {32{r_oh[i]}});
      sel_rresp = sel_rresp | (s_rresp[2*i +: 2] & {2{r_oh[i]}});
      sel_bresp = sel_bresp | (s_bresp[2*i +: 2] & {2{w_oh[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      r_sel    <= SEL_ERR;
      s_araddr <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (r_state == R_IDLE && arvalid) begin
        s_araddr <= araddr;
        r_sel    <= ar_dec;
      end
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    s_arvalid   = '0;
    s_rready    = '0;
    rvalid      = 1'b0;
    rdata       = '0;
    rresp       = RESP_OKAY;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_nxt = (ar_dec == SEL_ERR) ? R_ERR : R_ADDR;
      end
      R_ADDR: begin
        s_arvalid = r_oh;
        if (|(s_arready & r_oh)) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid   = sel_rvalid;
        rdata    = sel_rdata;
        rresp    = sel_rresp;
        s_rready = r_oh & {3{rready}};
        if (sel_rvalid && rready) r_state_nxt = R_IDLE;
      end
      R_ERR: begin
        rvalid = 1'b1;
        rresp  = RESP_DECERR;
        if (rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  // AW may be captured in the same cycle the pair completes, so take its decode directly then.
  assign w_sel_now = aw_got ? w_sel : aw_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_sel    <= SEL_ERR;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      s_awaddr <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        aw_got   <= 1'b1;
        s_awaddr <= awaddr;
        w_sel    <= aw_dec;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        s_wdata <= wdata;
        s_wstrb <= wstrb;
      end
      if (w_state == W_ADDR) begin
        if (sel_awready) aw_done <= 1'b1;
        if (sel_wready)  w_done  <= 1'b1;
      end
      if ((w_state == W_RESP || w_state == W_ERR) && w_state_nxt == W_IDLE) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    s_awvalid   = '0;
    s_wvalid    = '0;
    s_bready    = '0;
    bvalid      = 1'b0;
    bresp       = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        awready = !aw_got;
        wready  = !w_got;
        if ((aw_got || aw_hs) && (w_got || w_hs))
          w_state_nxt = (w_sel_now == SEL_ERR) ? W_ERR : W_ADDR;
      end
      W_ADDR: begin
        s_awvalid = w_oh & {3{!aw_done}};
        s_wvalid  = w_oh & {3{!w_done}};
        if ((aw_done || sel_awready) && (w_done || sel_wready)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid   = sel_bvalid;
        bresp    = sel_bresp;
        s_bready = w_oh & {3{bready}};
        if (sel_bvalid && bready) w_state_nxt = W_IDLE;
      end
      W_ERR: begin
        bvalid = 1'b1;
        bresp  = RESP_DECERR;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_xbar_1to3.sv
// Bench for axi_lite_xbar_1to3: directed scenarios then randomized traffic against a range-based reference.
module tb_axi_lite_xbar_1to3;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, rdata, awaddr, wdata, s_araddr, s_awaddr, s_wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb, s_wstrb;
  logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic [2:0]  s_wvalid, s_wready, s_bvalid, s_bready;
  logic [95:0] s_rdata;
  logic [5:0]  s_rresp, s_bresp;

  axi_lite_xbar_1to3 dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;
  typedef struct { int slv; logic [31:0] addr; } ar_exp_t;
  typedef struct { int slv; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } aw_exp_t;

  r_exp_t     exp_r[$];
  logic [1:0] exp_b[$];
  ar_exp_t    exp_ar[$];
  aw_exp_t    exp_aw[$];

  int n_chk = 0;
  int n_fail = 0;

  bit          ar_stall[3], b_stall[3];
  bit          r_pend[3], aw_seen[3], w_seen[3], b_pend[3];
  int          r_dly[3], b_dly[3];
  logic [31:0] r_addr[3], aw_a[3], w_d[3];
  logic [3:0]  w_s[3];
  bit          rr_force;
  logic        rr_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference decode straight from the memory map, using wide arithmetic instead of wrapping.
  function automatic int ref_slave(input logic [31:0] a);
    longint unsigned x;
    x = {32'h0, a};
    if (x >= 64'ha000_0048 && x < 64'ha000_0050) return 2;
    if (x >= 64'ha000_03f8 && x < 64'ha000_0400) return 1;
    if (x >= 64'h8000_0000 && x < 64'h8800_0000) return 0;
    return 3;
  endfunction

  function automatic logic [31:0] slv_rdata(input int s, input logic [31:0] a);
    case (s)
      0:       return ~a;
      1:       return {24'h0, a[7:0] ^ 8'h55};
      default: return a[2] ? 32'h0000_5678 : 32'h0000_1234;
    endcase
  endfunction

  function automatic logic [1:0] slv_resp(input int s);
    return (s == 1) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return 32'h8000_0000 | (r & 32'h07ff_fffc);
      1: return 32'h87ff_fffc;
      2: return 32'h8800_0000;
      3: return 32'h7fff_fffc;
      4: return 32'ha000_03f8 | (r & 32'h4);
      5: return 32'ha000_0048 | (r & 32'h4);
      6: return r[0] ? 32'ha000_0050 : 32'ha000_0044;
      7: return r[0] ? 32'ha000_03f4 : 32'ha000_0400;
      8: return 32'h8000_0000 | (r & 32'h0000_00fc);
      default: return r;
    endcase
  endfunction

  // Slave models: sample handshakes at negedge, drive new values just after posedge.
  initial begin : slaves
    ar_exp_t ae;
    aw_exp_t we;
    s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          r_pend[i] = 0; aw_seen[i] = 0; w_seen[i] = 0; b_pend[i] = 0;
        end
      end else begin
        if (|s_arvalid) chk("ar_expected", exp_ar.size() != 0, 1);
        for (int i = 0; i < 3; i++) begin
          if (s_arvalid[i] && s_arready[i]) begin
            if (exp_ar.size() == 0) fail_now("ar_unexpected");
            else begin
              ae = exp_ar.pop_front();
              chk("ar_slave", i, ae.slv);
              chk("ar_addr", s_araddr, ae.addr);
            end
            r_pend[i] = 1; r_addr[i] = s_araddr; r_dly[i] = $urandom_range(0, 2);
          end else if (s_rvalid[i] && s_rready[i]) r_pend[i] = 0;
          else if (r_pend[i] && r_dly[i] > 0) r_dly[i]--;
          if (s_awvalid[i] && s_awready[i]) begin aw_seen[i] = 1; aw_a[i] = s_awaddr; end
          if (s_wvalid[i] && s_wready[i]) begin w_seen[i] = 1; w_d[i] = s_wdata; w_s[i] = s_wstrb; end
          if (aw_seen[i] && w_seen[i]) begin
            if (exp_aw.size() == 0) fail_now("aw_unexpected");
            else begin
              we = exp_aw.pop_front();
              chk("aw_slave", i, we.slv);
              chk("aw_addr", aw_a[i], we.addr);
              chk("w_data", w_d[i], we.data);
              chk("w_strb", w_s[i], we.strb);
            end
            aw_seen[i] = 0; w_seen[i] = 0; b_pend[i] = 1; b_dly[i] = $urandom_range(0, 2);
          end
          if (s_bvalid[i] && s_bready[i]) b_pend[i] = 0;
          else if (b_pend[i] && b_dly[i] > 0 && !b_stall[i]) b_dly[i]--;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        s_arready[i] = !ar_stall[i] && ($urandom_range(0, 2) != 0);
        s_rvalid[i]  = r_pend[i] && r_dly[i] == 0;
        s_rdata[32*i +: 32] = r_pend[i] ? slv_rdata(i, r_addr[i]) : $urandom;
        s_rresp[2*i +: 2]   = slv_resp(i);
        s_awready[i] = ($urandom_range(0, 2) != 0);
        s_wready[i]  = ($urandom_range(0, 2) != 0);
        s_bvalid[i]  = b_pend[i] && b_dly[i] == 0 && !b_stall[i];
        s_bresp[2*i +: 2] = slv_resp(i);
      end
    end
  end

  initial begin : master_ready
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 3) != 0);
    end
  end

  // Master-side monitor: pops the scoreboard on every R/B handshake.
  initial begin : monitor
    logic pv, prdy;
    logic [31:0] pd;
    r_exp_t re;
    logic [1:0] be;
    pv = 0; prdy = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin pv = 0; continue; end
      if (pv && !prdy) begin
        chk("r_hold_vld", rvalid, 1);
        chk("r_hold_dat", rdata, pd);
      end
      if (rvalid && !rready) chk("s_rready_gated", s_rready, 0);
      if (rvalid && rready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin
          re = exp_r.pop_front();
          chk("rdata", rdata, re.data);
          chk("rresp", rresp, re.resp);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else begin
          be = exp_b.pop_front();
          chk("bresp", bresp, be);
        end
      end
      pv = rvalid; prdy = rready; pd = rdata;
    end
  end

  task automatic send_ar(input logic [31:0] a);
    int s, n;
    r_exp_t re;
    s = ref_slave(a);
    re.data = (s == 3) ? 32'h0 : slv_rdata(s, a);
    re.resp = (s == 3) ? RESP_DECERR : slv_resp(s);
    if (s != 3) exp_ar.push_back('{s, a});
    exp_r.push_back(re);
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    if (!arready) fail_now("ar_accept_timeout");
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    araddr = $urandom;
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                         input int aw_dly, input int w_dly);
    int s;
    s = ref_slave(a);
    if (s != 3) exp_aw.push_back('{s, a, d, st});
    exp_b.push_back((s == 3) ? RESP_DECERR : slv_resp(s));
    fork
      begin
        int n;
        repeat (aw_dly) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 200);
        if (!awready) fail_now("aw_accept_timeout");
        @(posedge clk); #1;
        awvalid = 1'b0; awaddr = $urandom;
      end
      begin
        int n;
        repeat (w_dly) begin @(posedge clk); #1; end
        wdata = d; wstrb = st; wvalid = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!wready && n < 200);
        if (!wready) fail_now("w_accept_timeout");
        @(posedge clk); #1;
        wvalid = 1'b0; wdata = $urandom;
      end
    join
  endtask

  task automatic wait_empty(input bit want_r, input bit want_b);
    int n;
    n = 0;
    while (((want_r && exp_r.size() != 0) ||
            (want_b && (exp_b.size() != 0 || exp_aw.size() != 0))) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst = 1'b1; arvalid = 1'b0; araddr = '0; awvalid = 1'b0; awaddr = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; rr_force = 0; rr_val = 1'b0;
    for (int i = 0; i < 3; i++) begin ar_stall[i] = 0; b_stall[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resps", {rresp, bresp}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // CLINT read: select appears one cycle after the AR accept.
    send_ar(32'ha000_0048);
    @(negedge clk);
    chk("clint_s_arvalid", s_arvalid, 3'b100);
    wait_empty(1, 0);
    @(negedge clk);
    chk("r_idle_arready", arready, 1);
    @(posedge clk); #1;

    // Unmapped read: DECERR the cycle after accept, no slave involved.
    send_ar(32'h0000_0000);
    @(negedge clk);
    chk("err_rvalid", rvalid, 1);
    chk("err_rresp", rresp, 2'b11);
    chk("err_rdata", rdata, 0);
    chk("err_no_s_arvalid", s_arvalid, 0);
    wait_empty(1, 0);

    // MEM write with AW two cycles ahead of W.
    send_wr(32'h8000_0010, 32'hdead_beef, 4'b0011, 0, 2);
    wait_empty(0, 1);

    // UART read completes while a MEM write waits on its B channel.
    b_stall[0] = 1;
    send_wr(32'h8000_0020, $urandom, 4'hf, 0, 0);
    send_ar(32'ha000_03fc);
    wait_empty(1, 0);
    @(negedge clk);
    chk("stalled_bvalid", bvalid, 0);
    chk("stalled_b_pending", exp_b.size(), 1);
    b_stall[0] = 0;
    wait_empty(0, 1);

    // Master back-pressure on R for three cycles.
    rr_force = 1; rr_val = 1'b0;
    send_ar(32'h8000_0100);
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    if (!rvalid) fail_now("hold_rvalid_timeout");
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, ~32'h8000_0100);
      chk("hold_s_rready", s_rready, 0);
    end
    rr_val = 1'b1;
    wait_empty(1, 0);
    rr_force = 0;

    // Reset while the read sits in R_ADDR.
    ar_stall[2] = 1;
    send_ar(32'ha000_0048);
    @(negedge clk);
    chk("pre_rst_s_arvalid", s_arvalid, 3'b100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_r.delete();
    exp_ar.delete();
    @(negedge clk);
    chk("post_rst_s_arvalid", s_arvalid, 0);
    chk("post_rst_arready", arready, 1);
    ar_stall[2] = 0;
    @(posedge clk); #1;
    send_ar(32'ha000_004c);
    wait_empty(1, 0);

    // Randomized independent read and write streams.
    fork
      for (int k = 0; k < 150; k++) send_ar(rand_addr());
      for (int k = 0; k < 150; k++)
        send_wr(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    join
    wait_empty(1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
